tempo_sequencer: RTL and testbench

Beat scheduler for the metronome/keyboard design. It selects the active tempo from preset switches or tap-tempo measurement and generates the per-beat strobe, the 14-step LED sweep position and the click gate. It also reports the effective BPM to the display logic. It sits between the switch/key inputs and the LED/speaker/HEX outputs.

---
 rtl/tempo_sequencer_if.sv | 34 +++
 rtl/tempo_sequencer.sv | 256 +++++++++++++++++++++++++
 tb/tb_tempo_sequencer.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tempo_sequencer_if.sv
// tempo_sequencer_if
//   Bundles the sequencer's control inputs and beat/display outputs.
//   master : the controller side (switches, tap key, consumers of the outputs)
//   slave  : the tempo_sequencer side
//   run       - sequencer enable (level)
//   bpm_sel   - 0 or 19..31 = tap mode, 1..18 = preset 60..230 BPM
//   tap       - raw active-low tap key
//   beat      - one-cycle strobe at the start of each beat
//   step      - sweep position 0..13
//   led       - one-hot sweep pattern (bounces 01 -> 80 -> 02)
//   click     - speaker gate
//   bpm       - effective tempo for the display
//   tap_valid - a tap period has been measured since reset
interface tempo_sequencer_if;
    logic       run;
    logic [4:0] bpm_sel;
    logic       tap;
    logic       beat;
    logic [3:0] step;
    logic [7:0] led;
    logic       click;
    logic [7:0] bpm;
    logic       tap_valid;

    modport master (
        output run, bpm_sel, tap,
        input  beat, step, led, click, bpm, tap_valid
    );

    modport slave (
        input  run, bpm_sel, tap,
        output beat, step, led, click, bpm, tap_valid
    );
endinterface

// File: rtl/tempo_sequencer.sv
// tempo_sequencer
//   Beat scheduler: picks the tempo from a preset or from tap-tempo
//   measurement, generates the beat strobe, the 14-step LED sweep and the
//   click gate, and reports the effective BPM.
//   clock - system clock
//   reset - asynchronous, active-low reset
//   bus   - tempo_sequencer_if.slave (run, bpm_sel, tap in; beat, step,
//           led, click, bpm, tap_valid out)
module tempo_sequencer #(
    parameter int CLK_HZ       = 50000000,
    parameter int STEPS        = 14,
    parameter int CLICK_CYC    = 2500000,
    parameter int DEBOUNCE_CYC = 1000000,
    parameter int MIN_BPM      = 60,
    parameter int MAX_BPM      = 230
) (
    input  logic              clock,
    input  logic              reset,
    tempo_sequencer_if.slave  bus
);
    localparam logic [63:0] DIV64 = 64'(CLK_HZ) * 64'd60;
    localparam logic [31:0] DIVIDEND = 32'(DIV64);

    function automatic logic [27:0] period_of(input int b);
        return 28'(DIV64 / 64'(b));
    endfunction

    localparam logic [27:0] P_MIN     = period_of(MAX_BPM);
    localparam logic [27:0] P_MAX     = period_of(MIN_BPM);
    localparam logic [27:0] P_120     = period_of(120);
    localparam logic [3:0]  LAST_STEP = 4'(STEPS - 1);

    typedef enum logic {IDLE, ARMED} tap_state_t;

    // Preset tables, fixed at elaboration. Unused codes fall back to 120 BPM.
    logic [27:0] preset_period [0:31];
    logic [7:0]  preset_bpm    [0:31];
    for (genvar gi = 0; gi < 32; gi++) begin : g_preset
        if (gi >= 1 && gi <= 18) begin : g_on
            assign preset_period[gi] = period_of(50 + 10 * gi);
            assign preset_bpm[gi]    = 8'(50 + 10 * gi);
        end else begin : g_off
            assign preset_period[gi] = P_120;
            assign preset_bpm[gi]    = 8'd120;
        end
    end

    // ---------------- tap input path ----------------
    logic        sync1_reg, sync2_reg, sync3_reg;
    logic [27:0] lockout_reg;
    logic        tap_accept;

    assign tap_accept = sync3_reg && !sync2_reg && (lockout_reg == 28'd0);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sync1_reg   <= 1'b1;
            sync2_reg   <= 1'b1;
            sync3_reg   <= 1'b1;
            lockout_reg <= '0;
        end else begin
            sync1_reg <= bus.tap;
            sync2_reg <= sync1_reg;
            sync3_reg <= sync2_reg;
            if (tap_accept)
                lockout_reg <= 28'(DEBOUNCE_CYC);
            else if (lockout_reg != 28'd0)
                lockout_reg <= lockout_reg - 28'd1;
        end
    end

    // ---------------- tap FSM ----------------
    tap_state_t  tap_state_reg;
    logic [27:0] tap_cnt_reg;
    logic [27:0] tap_period_reg;
    logic        tap_valid_reg;
    logic        div_start_reg;
    logic [28:0] period_sum;

    assign period_sum = {1'b0, tap_period_reg} + {1'b0, tap_cnt_reg};

    // The counter restarts at 1 because the accepting cycle itself belongs
    // to the next interval: two taps D cycles apart measure exactly D.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            tap_state_reg  <= IDLE;
            tap_cnt_reg    <= '0;
            tap_period_reg <= P_120;
            tap_valid_reg  <= 1'b0;
            div_start_reg  <= 1'b0;
        end else begin
            div_start_reg <= 1'b0;
            case (tap_state_reg)
                IDLE: begin
                    if (tap_accept) begin
                        tap_state_reg <= ARMED;
                        tap_cnt_reg   <= 28'd1;
                    end
                end
                ARMED: begin
                    // A tap on the timeout cycle is still measured.
                    if (tap_accept) begin
                        tap_cnt_reg <= 28'd1;
                        if (tap_cnt_reg >= P_MIN && tap_cnt_reg <= P_MAX) begin
                            tap_period_reg <= tap_valid_reg ? 28'(period_sum >> 1) : tap_cnt_reg;
                            tap_valid_reg  <= 1'b1;
                            div_start_reg  <= 1'b1;
                        end
                    end else if (tap_cnt_reg >= P_MAX) begin
                        tap_state_reg <= IDLE;
                    end else begin
                        tap_cnt_reg <= tap_cnt_reg + 28'd1;
                    end
                end
                default: tap_state_reg <= IDLE;
            endcase
        end
    end

    // ---------------- restoring divider: DIVIDEND / tap_period ----------------
    logic        div_busy_reg;
    logic [5:0]  div_cnt_reg;
    logic [31:0] div_quo_reg;
    logic [31:0] div_rem_reg;
    logic [27:0] div_den_reg;
    logic [7:0]  tap_bpm_reg;
    logic [32:0] rem_shift;
    logic        rem_ge;
    logic [31:0] quo_next;

    assign rem_shift = {div_rem_reg, div_quo_reg[31]};
    assign rem_ge    = rem_shift >= {5'd0, div_den_reg};
    assign quo_next  = {div_quo_reg[30:0], rem_ge};

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            div_busy_reg <= 1'b0;
            div_cnt_reg  <= '0;
            div_quo_reg  <= '0;
            div_rem_reg  <= '0;
            div_den_reg  <= P_120;
            tap_bpm_reg  <= 8'd120;
        end else if (div_start_reg) begin
            // A fresh start always wins over a divide in progress.
            div_busy_reg <= 1'b1;
            div_cnt_reg  <= 6'd32;
            div_quo_reg  <= DIVIDEND;
            div_rem_reg  <= '0;
            div_den_reg  <= tap_period_reg;
        end else if (div_busy_reg) begin
            div_quo_reg <= quo_next;
            div_rem_reg <= rem_ge ? 32'(rem_shift - {5'd0, div_den_reg}) : rem_shift[31:0];
            div_cnt_reg <= div_cnt_reg - 6'd1;
            if (div_cnt_reg == 6'd1) begin
                div_busy_reg <= 1'b0;
                tap_bpm_reg  <= quo_next[7:0];
            end
        end
    end

    // ---------------- tempo selection ----------------
    logic [4:0]  sel_reg;
    logic        is_preset;
    logic [27:0] sel_period;
    logic [7:0]  bpm_out;

    always_comb begin
        is_preset  = (sel_reg >= 5'd1) && (sel_reg <= 5'd18);
        sel_period = tap_valid_reg ? tap_period_reg : P_120;
        bpm_out    = tap_bpm_reg;
        if (is_preset) begin
            sel_period = preset_period[sel_reg];
            bpm_out    = preset_bpm[sel_reg];
        end
    end

    // ---------------- step engine ----------------
    logic        run_prev_reg;
    logic [27:0] period_active_reg;
    logic [27:0] acc_reg;
    logic [3:0]  step_reg;
    logic [7:0]  led_reg;
    logic        beat_reg;
    logic [27:0] click_cnt_reg;
    logic [28:0] acc_sum;
    logic [3:0]  step_inc;

    assign acc_sum  = {1'b0, acc_reg} + 29'(STEPS);
    assign step_inc = step_reg + 4'd1;

    // Sweep bounces: steps 0..7 light bits 0..7, steps 8..13 come back down.
    function automatic logic [7:0] led_of(input logic [3:0] s);
        if (s < 4'd8)
            return 8'h01 << s;
        return 8'h01 << (4'd14 - s);
    endfunction

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sel_reg           <= '0;
            run_prev_reg      <= 1'b0;
            period_active_reg <= P_120;
            acc_reg           <= '0;
            step_reg          <= '0;
            led_reg           <= '0;
            beat_reg          <= 1'b0;
            click_cnt_reg     <= '0;
        end else begin
            sel_reg      <= bus.bpm_sel;
            run_prev_reg <= bus.run;
            if (!bus.run) begin
                acc_reg       <= '0;
                step_reg      <= '0;
                led_reg       <= '0;
                beat_reg      <= 1'b0;
                click_cnt_reg <= '0;
            end else if (!run_prev_reg) begin
                acc_reg           <= '0;
                step_reg          <= '0;
                led_reg           <= 8'h01;
                beat_reg          <= 1'b1;
                click_cnt_reg     <= 28'(CLICK_CYC);
                period_active_reg <= sel_period;
            end else begin
                beat_reg <= 1'b0;
                if (click_cnt_reg != 28'd0)
                    click_cnt_reg <= click_cnt_reg - 28'd1;
                // Fractional accumulator: STEPS per cycle against period_active,
                // so a full sweep takes exactly period_active cycles.
                if (acc_sum >= {1'b0, period_active_reg}) begin
                    acc_reg <= 28'(acc_sum - {1'b0, period_active_reg});
                    if (step_reg == LAST_STEP) begin
                        // Tempo changes only take effect on a beat boundary.
                        step_reg          <= '0;
                        led_reg           <= 8'h01;
                        beat_reg          <= 1'b1;
                        click_cnt_reg     <= 28'(CLICK_CYC);
                        period_active_reg <= sel_period;
                    end else begin
                        step_reg <= step_inc;
                        led_reg  <= led_of(step_inc);
                    end
                end else begin
                    acc_reg <= acc_sum[27:0];
                end
            end
        end
    end

    assign bus.beat      = beat_reg;
    assign bus.step      = step_reg;
    assign bus.led       = led_reg;
    assign bus.click     = (click_cnt_reg != 28'd0);
    assign bus.bpm       = bpm_out;
    assign bus.tap_valid = tap_valid_reg;
endmodule

// File: tb/tb_tempo_sequencer.sv
// tb_tempo_sequencer
//   Directed bench for tempo_sequencer with CLK_HZ=1000 (P(120)=500,
//   P(150)=400, P_MIN=260, P_MAX=1000), CLICK_CYC=50, DEBOUNCE_CYC=10.
//   Expected beat intervals are queued when stimulus is issued; a monitor
//   pops one entry per observed beat. Other checks are hand-computed.
module tb_tempo_sequencer;
    logic clock = 1'b0;
    logic reset;

    tempo_sequencer_if bus ();

    tempo_sequencer #(
        .CLK_HZ      (1000),
        .STEPS       (14),
        .CLICK_CYC   (50),
        .DEBOUNCE_CYC(10),
        .MIN_BPM     (60),
        .MAX_BPM     (230)
    ) dut (
        .clock(clock),
        .reset(reset),
        .bus  (bus.slave)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int vectors = 0;
    int miscompares = 0;
    int exp_q[$];
    int last_beat = 0;
    int mon_exp = 0;
    int click_len = 0;

    task automatic check(input string name, input int act, input int exp);
        vectors++;
        if (act != exp) begin
            miscompares++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end else begin
            $display("ok   %s: %0d (cycle %0d)", name, act, cyc);
        end
    endtask

    // Beat monitor: 0 in the queue marks the start beat after run rises.
    always @(negedge clock) begin
        if (reset && bus.beat) begin
            if (exp_q.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL beat_unexpected: beat at cycle %0d, expected none", cyc);
            end else begin
                mon_exp = exp_q.pop_front();
                if (mon_exp == 0) begin
                    check("start_beat_led", int'(bus.led), 1);
                end else begin
                    check("beat_interval", cyc - last_beat, mon_exp);
                end
                last_beat = cyc;
            end
        end
    end

    // Click gate width: every completed pulse must be CLICK_CYC cycles.
    always @(negedge clock) begin
        if (bus.click) begin
            click_len++;
        end else if (click_len != 0) begin
            if (reset && bus.run)
                check("click_width", click_len, 50);
            click_len = 0;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) tick();
    endtask

    task automatic sample_at(input int t);
        wait_until(t);
        @(negedge clock);
    endtask

    task automatic press(input bit bounce, output int e);
        e = cyc;
        bus.tap = 1'b0;
        tick();
        tick();
        bus.tap = 1'b1;
        if (bounce) begin
            tick();
            tick();
            bus.tap = 1'b0;
            tick();
            tick();
            bus.tap = 1'b1;
        end
    endtask

    task automatic led_walk();
        logic [7:0] tbl [0:13];
        tbl = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40,
                8'h80, 8'h40, 8'h20, 8'h10, 8'h08, 8'h04, 8'h02};
        for (int i = 0; i < 14; i++) begin
            for (int k = 0; k < 100; k++) begin
                @(negedge clock);
                if (int'(bus.step) == i) break;
            end
            check($sformatf("led_step%0d", i), int'(bus.led), int'(tbl[i]));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int ra, rb, rd, rr;
        int e1, e2, e3, e4, e5, e6, e7, e8, ea, eb;

        reset       = 1'b0;
        bus.run     = 1'b0;
        bus.bpm_sel = 5'd7;
        bus.tap     = 1'b1;

        // ---- reset state ----
        tick(); tick(); tick();
        @(negedge clock);
        check("rst_step", int'(bus.step), 0);
        check("rst_led", int'(bus.led), 0);
        check("rst_beat", int'(bus.beat), 0);
        check("rst_click", int'(bus.click), 0);
        check("rst_bpm", int'(bus.bpm), 120);
        check("rst_tap_valid", int'(bus.tap_valid), 0);
        tick();
        reset = 1'b1;
        tick(); tick();

        // ---- preset 120 BPM: beat every 500, LED walk ----
        bus.run = 1'b1;
        ra = cyc;
        exp_q.push_back(0);
        exp_q.push_back(500);
        exp_q.push_back(500);
        tick();
        led_walk();
        sample_at(ra + 10);
        check("preset7_bpm", int'(bus.bpm), 120);
        wait_until(ra + 1100);
        bus.run = 1'b0;
        sample_at(ra + 1101);
        check("stop_step", int'(bus.step), 0);
        check("stop_led", int'(bus.led), 0);

        // ---- tap mode: two taps 400 apart ----
        tick();
        bus.bpm_sel = 5'd0;
        tick(); tick();
        @(negedge clock);
        check("tapmode_default_bpm", int'(bus.bpm), 120);
        tick();
        press(1'b0, e1);
        wait_until(e1 + 400);
        press(1'b0, e2);
        sample_at(e2 + 2);
        check("tap_valid_before", int'(bus.tap_valid), 0);
        tick();
        sample_at(e2 + 3);
        check("tap_valid_after", int'(bus.tap_valid), 1);
        tick();
        sample_at(e2 + 35);
        check("bpm_before_div_done", int'(bus.bpm), 120);
        tick();
        sample_at(e2 + 36);
        check("bpm_tap150", int'(bus.bpm), 150);
        tick();

        // Run at 400; third tap 600 later lands mid-beat, so 500 starts a beat later.
        wait_until(e2 + 50);
        bus.run = 1'b1;
        rb = cyc;
        exp_q.push_back(0);
        exp_q.push_back(400);
        exp_q.push_back(400);
        exp_q.push_back(500);
        wait_until(e2 + 600);
        press(1'b0, e3);
        sample_at(e3 + 36);
        check("bpm_tap_avg120", int'(bus.bpm), 120);
        tick();
        wait_until(rb + 1400);
        bus.run = 1'b0;

        // ---- fast taps, bounce lockout, P_MAX boundary ----
        wait_until(e3 + 1200);
        press(1'b0, e4);
        wait_until(e4 + 100);
        press(1'b0, e5);
        sample_at(e5 + 40);
        check("bpm_fast_tap_ignored", int'(bus.bpm), 120);
        tick();
        wait_until(e5 + 600);
        press(1'b1, e6);
        sample_at(e6 + 40);
        check("bpm_after_600", int'(bus.bpm), 109);
        tick();
        wait_until(e6 + 400);
        press(1'b0, e7);
        sample_at(e7 + 40);
        check("bpm_bounce_locked_out", int'(bus.bpm), 126);
        tick();
        wait_until(e7 + 1000);
        press(1'b0, e8);
        sample_at(e8 + 40);
        check("bpm_tap_at_pmax", int'(bus.bpm), 81);
        tick();

        // ---- preset switch 7 -> 1 mid-beat ----
        bus.bpm_sel = 5'd7;
        tick(); tick();
        bus.run = 1'b1;
        rd = cyc;
        exp_q.push_back(0);
        exp_q.push_back(500);
        exp_q.push_back(500);
        exp_q.push_back(1000);
        wait_until(rd + 700);
        bus.bpm_sel = 5'd1;
        sample_at(rd + 702);
        check("preset1_bpm", int'(bus.bpm), 60);
        tick();

        // ---- reset mid-beat and mid-divide ----
        wait_until(rd + 2100);
        press(1'b0, ea);
        wait_until(ea + 400);
        press(1'b0, eb);
        wait_until(eb + 10);
        reset = 1'b0;
        bus.bpm_sel = 5'd0;
        #1;
        check("arst_step", int'(bus.step), 0);
        check("arst_led", int'(bus.led), 0);
        check("arst_click", int'(bus.click), 0);
        check("arst_bpm", int'(bus.bpm), 120);
        check("arst_tap_valid", int'(bus.tap_valid), 0);
        tick(); tick(); tick();
        reset = 1'b1;
        rr = cyc;
        exp_q.push_back(0);
        exp_q.push_back(500);
        sample_at(rr + 60);
        check("post_reset_bpm", int'(bus.bpm), 120);
        check("post_reset_tap_valid", int'(bus.tap_valid), 0);
        tick();
        wait_until(rr + 600);
        bus.run = 1'b0;

        for (int k = 0; k < 100 && exp_q.size() != 0; k++) tick();
        while (exp_q.size() != 0) begin
            vectors++;
            miscompares++;
            $display("FAIL beat_missing: no beat seen, expected interval %0d", exp_q.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
